// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared
// 32-bit ALU as its only adder. The control unit starts it with start and
// sees busy while it runs. A one-cycle done pulse marks the cycle in which
// product becomes valid.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (highest priority)
//   start         multiply request, sampled only in IDLE
//   multiplicand  operand A, sampled with an accepted start
//   multiplier    operand B, sampled with an accepted start
//   busy          high while in RUN (registered)
//   done          one-cycle pulse, product valid from here on (registered)
//   product       zero-extended A*B, held until the next result is loaded
//   alu_a/alu_b   ALU operands, decoded from state and registers
//   alu_op        ALU opcode: 3'b101 ADD in RUN, 3'b000 AND otherwise
//   alu_result    combinational ALU result for the current alu_a/b/op
module alu_mult_sequencer #(
  parameter int OP_WIDTH   = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OP_WIDTH-1:0] multiplicand,
  input  logic [OP_WIDTH-1:0] multiplier,
  output logic                busy,
  output logic                done,
  output logic [31:0]         product,
  output logic [31:0]         alu_a,
  output logic [31:0]         alu_b,
  output logic [2:0]          alu_op,
  input  logic [31:0]         alu_result
);

  localparam int              CNT_W     = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_WIDTH - 1);
  localparam logic [2:0]      OP_ADD    = 3'b101;
  localparam logic [2:0]      OP_AND    = 3'b000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [31:0]         acc;
  logic [31:0]         mcand_sh;
  logic [OP_WIDTH-1:0] mplier;
  logic [CNT_W-1:0]    count;

  logic [OP_WIDTH-1:0] mplier_nxt;
  logic                run_last;
  logic [31:0]         acc_nxt;

  assign mplier_nxt = mplier >> 1;
  // Stop after the last bit position, or early once no set multiplier
  // bits remain above the one consumed this cycle.
  assign run_last   = (count == CNT_LAST) || (EARLY_EXIT && (mplier_nxt == '0));
  // Partial sum after this cycle: add the shifted multiplicand only when
  // the current multiplier bit is set.
  assign acc_nxt    = mplier[0] ? alu_result : acc;

  // ALU is only driven with real operands in RUN; otherwise it sees a
  // quiescent AND of zeros so it does not toggle for nothing.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_AND;
    if (state == RUN) begin
      alu_a  = acc;
      alu_b  = mcand_sh;
      alu_op = OP_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
      acc      <= '0;
      mcand_sh <= '0;
      mplier   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            acc      <= '0;
            mcand_sh <= 32'(multiplicand);
            mplier   <= multiplier;
            count    <= '0;
            if (EARLY_EXIT && (multiplier == '0)) begin
              // Nothing to add: finish immediately with a zero product.
              state   <= DONE;
              done    <= 1'b1;
              product <= '0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          acc      <= acc_nxt;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier_nxt;
          count    <= count + 1'b1;
          if (run_last) begin
            // Final sum is loaded on the same edge, so done and a valid
            // product appear together in the next cycle.
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            product <= acc_nxt;
          end
        end

        DONE: begin
          // start is ignored here; a new request is taken in IDLE.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed + random bench for alu_mult_sequencer. Two instances: the default
// (EARLY_EXIT=1) and one with EARLY_EXIT=0, each with its own ALU model.
module tb_alu_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start, start0;
  logic [15:0] mcand, mplier;
  logic        busy, done, busy0, done0;
  logic [31:0] product, product0;
  logic [31:0] alu_a, alu_b, alu_res, alu_a0, alu_b0, alu_res0;
  logic [2:0]  alu_op, alu_op0;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  alu_mult_sequencer #(.OP_WIDTH(16), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start),
    .multiplicand(mcand), .multiplier(mplier),
    .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_res)
  );

  alu_mult_sequencer #(.OP_WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start0),
    .multiplicand(mcand), .multiplier(mplier),
    .busy(busy0), .done(done0), .product(product0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_op(alu_op0), .alu_result(alu_res0)
  );

  // Shared-ALU model: ADD and AND are the only opcodes the sequencer uses.
  always_comb begin
    alu_res = '0;
    if (alu_op == 3'b101)      alu_res = alu_a + alu_b;
    else if (alu_op == 3'b000) alu_res = alu_a & alu_b;
  end
  always_comb begin
    alu_res0 = '0;
    if (alu_op0 == 3'b101)      alu_res0 = alu_a0 + alu_b0;
    else if (alu_op0 == 3'b000) alu_res0 = alu_a0 & alu_b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected number of RUN cycles for a given multiplier.
  function automatic int exp_runs(input logic [15:0] b, input bit ee);
    int k;
    if (!ee) return 16;
    k = 0;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  // Counts falling edges until done; cyc=1 is the cycle after the start edge.
  // Checks alu_op against busy each cycle along the way.
  task automatic wait_done(input bit sel, input int maxc, output int cyc, output int bcyc);
    logic b, d;
    logic [2:0] op;
    cyc  = 0;
    bcyc = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      cyc = i;
      b  = sel ? busy0   : busy;
      d  = sel ? done0   : done;
      op = sel ? alu_op0 : alu_op;
      if (b) bcyc++;
      chk("alu_op_vs_busy", 32'(op), b ? 32'd5 : 32'd0);
      if (d) return;
    end
    total++;
    bad++;
    $error("FAIL done_timeout observed=no_done expected=done_within_%0d", maxc);
  endtask

  task automatic pop_chk(input bit sel);
    logic [31:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=done expected=no_done");
    end else begin
      e = sb.pop_front();
      chk("product", sel ? product0 : product, e);
    end
  endtask

  // Called at a falling edge; leaves the bench at a falling edge.
  task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b);
    int cyc, bcyc, k;
    k = exp_runs(b, !sel);
    sb.push_back(32'(a) * 32'(b));
    mcand  = a;
    mplier = b;
    if (sel) start0 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start0 = 1'b0;
    wait_done(sel, 40, cyc, bcyc);
    chk("done_cycle", 32'(cyc), 32'(k + 1));
    chk("busy_cycles", 32'(bcyc), 32'(k));
    pop_chk(sel);
    @(negedge clk);
    chk("done_single_pulse", 32'(sel ? done0 : done), 32'd0);
  endtask

  initial begin
    int cyc, bcyc;
    logic [15:0] ra, rb;
    reset  = 1'b1;
    start  = 1'b0;
    start0 = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",    32'(busy),   32'd0);
    chk("rst_done",    32'(done),   32'd0);
    chk("rst_product", product,     32'd0);
    chk("rst_alu_op",  32'(alu_op), 32'd0);
    chk("rst_alu_a",   alu_a,       32'd0);
    chk("rst_alu_b",   alu_b,       32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(1'b0, 16'd15, 16'd12);          // 4 RUN, done in 5, 180
    run_op(1'b0, 16'hFFFF, 16'hFFFF);      // 16 RUN, done in 17
    run_op(1'b0, 16'd1234, 16'd0);         // done in 1, never busy
    run_op(1'b1, 16'd1234, 16'd0);         // no early exit: done in 17
    run_op(1'b1, 16'd15, 16'd12);
    run_op(1'b0, 16'h8000, 16'd1);         // single RUN cycle
    run_op(1'b0, 16'd1, 16'h8000);         // top bit only

    // start held high; operands changed during RUN must not be picked up
    sb.push_back(32'd63);
    sb.push_back(32'd9);
    mcand  = 16'd7;
    mplier = 16'd9;
    start  = 1'b1;
    @(posedge clk);
    #1;
    mcand  = 16'd3;
    mplier = 16'd3;
    wait_done(1'b0, 40, cyc, bcyc);
    chk("held_done1_cycle", 32'(cyc), 32'd5);
    chk("held_busy1",       32'(bcyc), 32'd4);
    pop_chk(1'b0);
    wait_done(1'b0, 40, cyc, bcyc);
    start = 1'b0;
    chk("held_done2_gap", 32'(cyc), 32'd4);
    chk("held_busy2",     32'(bcyc), 32'd2);
    pop_chk(1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("held_no_third_done", 32'(done), 32'd0);
      chk("held_no_third_busy", 32'(busy), 32'd0);
    end

    // reset during the third RUN cycle of 200*300
    mcand  = 16'd200;
    mplier = 16'd300;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy",    32'(busy),   32'd0);
    chk("midrst_done",    32'(done),   32'd0);
    chk("midrst_product", product,     32'd0);
    chk("midrst_alu_op",  32'(alu_op), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'd0);
    run_op(1'b0, 16'd200, 16'd300);        // 9 RUN, 60000

    // Random sweep, mixing small/zero multipliers to exercise early exit
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom_range(0, 15));
        1:       rb = 16'($urandom_range(0, 255));
        default: rb = 16'($urandom);
      endcase
      run_op(1'b0, ra, rb);
    end
    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      run_op(1'b1, ra, rb);
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle unsigned multiply controller that computes the product by shift-and-add, using the shared 32-bit ALU as its only adder.
- It drives the ALU operand and opcode inputs and samples the ALU result, so no second adder is needed for MULT.
- It sits beside the main datapath and is started by the control unit through a start/busy/done handshake.

Parameters:
- OP_WIDTH, 16, operand width in bits. Legal range is 2..16, so that 2*OP_WIDTH <= 32 and ALU ADD can never overflow.
- EARLY_EXIT, 1, when set RUN terminates as soon as the remaining multiplier bits are zero. When 0, RUN always takes OP_WIDTH cycles.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a multiply. Sampled only in IDLE.
- multiplicand  in  OP_WIDTH  operand A. Sampled with start.
- multiplier  in  OP_WIDTH  operand B. Sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; product is valid from this cycle onward.
- product  out  32  zero-extended unsigned A*B. Holds until the next accepted start.
- alu_a  out  32  ALU operand a.
- alu_b  out  32  ALU operand b.
- alu_op  out  3  ALU opcode. 3'b101 = ADD, 3'b000 = AND (quiescent).
- alu_result  in  32  ALU result, combinational from alu_a/alu_b/alu_op within the same cycle.

Behaviour:
- One clock domain; reset is synchronous and active-high. reset has priority over every other input, including start, at any state.
- Reset values: state=IDLE, busy=0, done=0, product=0, acc=0, mcand_sh=0, mplier=0, count=0.
- Outputs are registered, except alu_a/alu_b/alu_op, which are decoded from state and registers.
- Internal registers:
  - acc, 32 bits.
  - mcand_sh, 32 bits: shifted multiplicand.
  - mplier, OP_WIDTH bits: remaining multiplier.
  - count, clog2(OP_WIDTH) bits.
- IDLE state:
  - busy=0, done=0; alu_a=0, alu_b=0, alu_op=3'b000.
  - On start=1: acc<=0, mcand_sh<={zeros,multiplicand}, mplier<=multiplier, count<=0.
  - If EARLY_EXIT=1 and multiplier==0: go to DONE and load product<=0.
  - Otherwise go to RUN.
- RUN state:
  - busy=1; alu_a=acc, alu_b=mcand_sh, alu_op=3'b101 every cycle.
  - At each edge:
    - If mplier[0]=1, acc<=alu_result; otherwise acc holds.
    - mcand_sh<=mcand_sh<<1, mplier<=mplier>>1, count<=count+1.
  - Exit condition: count==OP_WIDTH-1, or (EARLY_EXIT=1 and (mplier>>1)==0).
  - On exit: go to DONE and load product<=(mplier[0] ? alu_result : acc), i.e. the final sum, in the same edge.
- DONE state:
  - done=1 for exactly this cycle; busy=0; ALU outputs are quiescent.
  - Unconditional transition to IDLE. start is ignored in DONE.
- start while in RUN or DONE is ignored, with no queuing. Operand inputs are don't-care outside the accepting IDLE cycle.
- Latency, counting start sampled at edge 0:
  - EARLY_EXIT=0: RUN covers cycles 1..OP_WIDTH, done is high in cycle OP_WIDTH+1 (17 for the default).
  - EARLY_EXIT=1: RUN lasts k cycles, where k = index of the highest set multiplier bit + 1; done is high in cycle k+1.
  - EARLY_EXIT=1 with multiplier=0: done is high in cycle 1.
- Arithmetic: all quantities are unsigned; product = multiplicand*multiplier exactly, with no truncation since the result fits in 32 bits. The ALU zero flag is not used.
- Reset mid-RUN: the next cycle is IDLE with the reset values above. No done pulse; the partial acc is discarded; product=0.
- Back-to-back operation: a new start may be accepted in the IDLE cycle immediately after DONE, so the minimum spacing between done pulses is k+2 cycles.

Test Plan:
- Default params with the real alu instance connected, multiplicand=15, multiplier=12 → busy for 4 cycles, done in cycle 5, product=180.
- multiplicand=65535, multiplier=65535 → 16 RUN cycles, done in cycle 17, product=32'hFFFE0001.
- multiplier=0, multiplicand=1234 → done in cycle 1, busy never high, product=0. With EARLY_EXIT=0 instead → done in cycle 17, product=0.
- start=1 held continuously with 7×9 then 3×3 presented → first done shows product=63, and the operands are re-sampled only in the IDLE cycle after DONE. Second product=9; no second start is accepted during RUN.
- reset asserted in the 3rd RUN cycle of 200×300 → next cycle busy=0, done=0, product=0, alu_op=3'b000. A subsequent 200×300 yields 60000.
- Random sweep of 1000 operand pairs → product matches the reference multiplication every time, done pulses exactly once per accepted start, and alu_op=3'b101 only while busy.
